qadd_pipe: RTL and testbench

- Pipelined, parametrised sign-magnitude Q-format adder/accumulator with valid/ready handshakes on input and output.
- Number format: bit N-1 is the sign, bits N-2:0 are the magnitude, Q fractional bits.
- Two modes per transaction: plain add (a+b) or running accumulate (acc+a).
- Adds overflow detection, an accumulator and backpressure; the earlier combinational adder has none of these.
- Sits between fixed-point datapath stages (filter taps, MAC chains) and accepts one transaction per cycle.

---
 rtl/qadd_pipe_pkg.sv | 17 +
 rtl/qadd_sm_core.sv | 69 ++++++
 rtl/qadd_pipe.sv | 140 ++++++++++++++
 tb/tb_qadd_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qadd_pipe_pkg.sv
// qadd_pkg: shared definitions for the qadd_pipe sign-magnitude adder.
// Holds the transaction mode encoding and the magnitude ceiling helper.
package qadd_pkg;

   // Per-transaction mode: plain a+b, or running acc+a
   typedef enum logic {
      QADD_MODE_ADD = 1'b0,
      QADD_MODE_ACC = 1'b1
   } qadd_mode_e;

   // Largest representable magnitude for an n-bit sign-magnitude word, 2^(n-1)-1.
   // The result is 64 bits wide, which covers word widths up to 65 bits.
   function automatic logic [63:0] qadd_mag_max(input int n);
      return {64{1'b1}} >> (65 - n);
   endfunction

endpackage : qadd_pkg

// File: rtl/qadd_sm_core.sv
// qadd_sm_core: purely combinational sign-magnitude adder.
// Same signs add magnitudes (carry out = overflow); differing signs subtract
// the smaller magnitude from the larger. A zero result is always +0.
// Build option: define QADD_PIPE_SATURATE_EN to clamp overflowed magnitudes
// to the maximum instead of wrapping them.
module qadd_sm_core
   import qadd_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] c_o,
   output logic         ovf_o
);

   localparam int MW = N - 1;

   logic          sa;
   logic          sb;
   logic [MW-1:0] ma;
   logic [MW-1:0] mb;
   logic [N-1:0]  sum;
   logic [MW-1:0] mag;
   logic          sign;
   logic          ovf;

   assign sa  = a_i[N-1];
   assign sb  = b_i[N-1];
   assign ma  = a_i[MW-1:0];
   assign mb  = b_i[MW-1:0];
   // One extra bit so the carry out of the magnitude add is the overflow flag
   assign sum = {1'b0, ma} + {1'b0, mb};

`ifdef QADD_PIPE_SATURATE_EN
   localparam logic [MW-1:0] MAG_MAX = MW'(qadd_mag_max(N));
`endif

   // Select magnitude and sign of the result from the operand signs
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      mag  = '0;
      sign = 1'b0;
      ovf  = 1'b0;
      if (sa == sb) begin
         sign = sa;
         ovf  = sum[N-1];
`ifdef QADD_PIPE_SATURATE_EN
         mag  = ovf ? MAG_MAX : sum[MW-1:0];
`else
         mag  = sum[MW-1:0];
`endif
      end else if (ma >= mb) begin
         mag  = ma - mb;
         sign = sa;
      end else begin
         mag  = mb - ma;
         sign = sb;
      end
      // Never emit -0, whether from cancellation, wrap or a -0 operand
      if (mag == '0) begin
         sign = 1'b0;
      end
   end

   assign c_o   = {sign, mag};
   assign ovf_o = ovf;

endmodule : qadd_sm_core

// File: rtl/qadd_pipe.sv
// qadd_pipe: two-stage pipelined sign-magnitude Q-format adder/accumulator
// with valid/ready handshakes on both sides. Stage S1 holds the accepted
// operands; stage S2 holds the result. In accumulate mode the second operand
// is the running accumulator (or zero on the first transaction of a run).
// Build option: QADD_PIPE_SATURATE_EN (see qadd_sm_core) selects saturating
// instead of wrapping overflow; flags behave the same in both builds.
module qadd_pipe
   import qadd_pkg::*;
#(
   parameter int N = 16,
   parameter int Q = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_acc,
   input  logic         in_first,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_c,
   output logic         out_ovf,
   output logic         acc_ovf
);

   // Q only documents the binary point; the arithmetic does not depend on it
   if (N < 4 || Q < 0 || Q >= N - 1) begin : g_param_check
      $error("qadd_pipe: requires N >= 4 and 0 <= Q < N-1");
   end

   // S1 payload: operands plus per-transaction control
   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      qadd_mode_e   mode;
      logic         first;
   } s1_t;

   logic         s1_valid_q, s1_valid_d;
   s1_t          s1_q, s1_d;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] out_c_q, out_c_d;
   logic         out_ovf_q, out_ovf_d;
   logic [N-1:0] acc_q, acc_d;
   logic         acc_ovf_q, acc_ovf_d;

   logic         s2_adv;
   logic         s1_move;
   logic         in_fire;
   logic         acc_mode;
   logic [N-1:0] core_b;
   logic [N-1:0] core_c;
   logic         core_ovf;

   // Handshake: S2 can take new data when empty or draining; S1 likewise.
   // in_ready depends only on registers and out_ready, never on in_valid.
   assign s2_adv   = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;
   assign in_fire  = in_valid && in_ready;
   assign s1_move  = s1_valid_q && s2_adv;

   // The accumulator is read as S1's operand in the same cycle the previous
   // accumulate writes it, so back-to-back accumulates need no forwarding.
   assign acc_mode = (s1_q.mode == QADD_MODE_ACC);
   assign core_b   = acc_mode ? (s1_q.first ? '0 : acc_q) : s1_q.b;

   qadd_sm_core #(
      .N (N)
   ) u_core (
      .a_i   (s1_q.a),
      .b_i   (core_b),
      .c_o   (core_c),
      .ovf_o (core_ovf)
   );

   // S1 next state: load on accept, empty when handed on to S2
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_d.a     = in_a;
         s1_d.b     = in_b;
         s1_d.mode  = qadd_mode_e'(in_acc);
         s1_d.first = in_first;
      end else if (s1_move) begin
         s1_valid_d = 1'b0;
      end
   end

   // S2 and accumulator next state: result data holds while stalled
   always_comb begin
      out_valid_d = out_valid_q;
      out_c_d     = out_c_q;
      out_ovf_d   = out_ovf_q;
      acc_d       = acc_q;
      acc_ovf_d   = acc_ovf_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
      end
      if (s1_move) begin
         out_c_d   = core_c;
         out_ovf_d = core_ovf;
         if (acc_mode) begin
            acc_d     = core_c;
            acc_ovf_d = (s1_q.first ? 1'b0 : acc_ovf_q) | core_ovf;
         end
      end
   end

   // State registers with synchronous reset that discards in-flight data
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         out_c_q     <= '0;
         out_ovf_q   <= 1'b0;
         acc_q       <= '0;
         acc_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         out_valid_q <= out_valid_d;
         out_c_q     <= out_c_d;
         out_ovf_q   <= out_ovf_d;
         acc_q       <= acc_d;
         acc_ovf_q   <= acc_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_c     = out_c_q;
   assign out_ovf   = out_ovf_q;
   assign acc_ovf   = acc_ovf_q;

endmodule : qadd_pipe

// File: tb/tb_qadd_pipe.sv
// tb_qadd_pipe: self-checking bench for qadd_pipe (N=16, Q=8).
// Directed cases from the design's corner cases, then randomized traffic with
// random backpressure and occasional reset, scored against a signed-integer
// reference model and an in-order expected-result queue.
module tb_qadd_pipe;

   localparam int N    = 16;
   localparam int Q    = 8;
   localparam int MW   = N - 1;
   localparam int MAXM = (1 << (N - 1)) - 1;

`ifdef QADD_PIPE_SATURATE_EN
   localparam logic [N-1:0] EXP_OVF_POS   = 16'h7FFF;
   localparam logic [N-1:0] EXP_OVF_NEG   = 16'hFFFF;
   localparam logic [N-1:0] EXP_ACC_OVF   = 16'h7FFF;
   localparam logic [N-1:0] EXP_ACC_AFTER = 16'h7FFE;
`else
   localparam logic [N-1:0] EXP_OVF_POS   = 16'h0100;
   localparam logic [N-1:0] EXP_OVF_NEG   = 16'h8100;
   localparam logic [N-1:0] EXP_ACC_OVF   = 16'h0100;
   localparam logic [N-1:0] EXP_ACC_AFTER = 16'h00FF;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         in_acc;
   logic         in_first;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_c;
   logic         out_ovf;
   logic         acc_ovf;

   always #5 clk = ~clk;

   qadd_pipe #(
      .N (N),
      .Q (Q)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_acc    (in_acc),
      .in_first  (in_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_ovf   (out_ovf),
      .acc_ovf   (acc_ovf)
   );

   int n_vec     = 0;
   int n_miscmp  = 0;
   int n_pops    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: interpret words as signed integers, add, then re-encode
   // Returns {ovf, sign, magnitude}
   function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
      int   va;
      int   vb;
      int   s;
      int   m;
      logic ovf;
      logic sign;
      va = a[N-1] ? -int'(a[N-2:0]) : int'(a[N-2:0]);
      vb = b[N-1] ? -int'(b[N-2:0]) : int'(b[N-2:0]);
      s  = va + vb;
      m  = (s < 0) ? -s : s;
      ovf = (m > MAXM);
`ifdef QADD_PIPE_SATURATE_EN
      if (ovf) m = MAXM;
`else
      m = m % (MAXM + 1);
`endif
      sign = (s < 0) && (m != 0);
      return {ovf, sign, m[N-2:0]};
   endfunction

   function automatic logic [N-1:0] rand_word();
      logic [MW-1:0] m;
      case ($urandom_range(0, 2))
         0:       m = MW'($urandom_range(0, MAXM));
         1:       m = MW'($urandom_range(MAXM - 255, MAXM));
         default: m = MW'($urandom_range(0, 15));
      endcase
      return {1'($urandom_range(0, 1)), m};
   endfunction

   // Expected results in issue order
   typedef struct {
      logic [N-1:0] c;
      logic         ovf;
      logic         accovf;
   } exp_t;

   exp_t         sb_q[$];
   logic [N-1:0] m_acc;
   logic         m_accovf;

   // Monitor: samples at the falling edge, scoring transfers that the next
   // rising edge will perform, and checking stability under backpressure
   initial begin
      logic         hold;
      logic [N-1:0] hold_c;
      logic         hold_ovf;
      logic [N:0]   r;
      exp_t         e;
      hold     = 1'b0;
      hold_c   = '0;
      hold_ovf = 1'b0;
      m_acc    = '0;
      m_accovf = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb_q.delete();
            m_acc    = '0;
            m_accovf = 1'b0;
            hold     = 1'b0;
         end else begin
            if (hold) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_c", 32'(out_c), 32'(hold_c));
               check("hold_ovf", 32'(out_ovf), 32'(hold_ovf));
            end
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  check("spurious_out_valid", 32'(out_valid), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("sb_out_c", 32'(out_c), 32'(e.c));
                  check("sb_out_ovf", 32'(out_ovf), 32'(e.ovf));
                  check("sb_acc_ovf", 32'(acc_ovf), 32'(e.accovf));
                  n_pops++;
               end
            end
            if (in_valid && in_ready) begin
               if (in_acc) begin
                  r        = ref_add(in_a, in_first ? '0 : m_acc);
                  m_acc    = r[N-1:0];
                  m_accovf = (in_first ? 1'b0 : m_accovf) | r[N];
               end else begin
                  r = ref_add(in_a, in_b);
               end
               e.c      = r[N-1:0];
               e.ovf    = r[N];
               e.accovf = m_accovf;
               sb_q.push_back(e);
            end
            hold     = out_valid && !out_ready;
            hold_c   = out_c;
            hold_ovf = out_ovf;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_acc   = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic acc, input logic first);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_acc   = acc;
      in_first = first;
   endtask

   // One transaction through an empty pipeline with out_ready=1
   task automatic single(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic acc, input logic first,
                         input logic [N-1:0] exp_c, input logic exp_ovf, input logic exp_aovf);
      out_ready = 1'b1;
      drive(a, b, acc, first);
      tick();
      idle_inputs();
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_c"}, 32'(out_c), 32'(exp_c));
      check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
      check({tag, "_aovf"}, 32'(acc_ovf), 32'(exp_aovf));
      tick();
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      idle_inputs();
      for (int i = 0; i < 40; i++) begin
         if (sb_q.size() == 0 && !out_valid) break;
         tick();
      end
      check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
      check({tag, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] bp_a [4];
      int           idx;
      int           pops0;
      logic         acc_now;

      rst       = 1'b1;
      out_ready = 1'b0;
      idle_inputs();
      repeat (3) tick();

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_c", 32'(out_c), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_acc_ovf", 32'(acc_ovf), 32'd0);
      rst = 1'b0;
      tick();

      // Plain adds: mixed signs, cancellation, -0 input, overflow both signs
      single("mixed", 16'h0180, 16'h8100, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0);
      single("cancel", 16'h0100, 16'h8100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      single("neg_zero", 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      single("ovf_pos", 16'h7F00, 16'h0200, 1'b0, 1'b0, EXP_OVF_POS, 1'b1, 1'b0);
      single("ovf_neg", 16'hFF00, 16'h8200, 1'b0, 1'b0, EXP_OVF_NEG, 1'b1, 1'b0);

      // Back-to-back accumulate: results on consecutive cycles
      out_ready = 1'b1;
      drive(16'h0100, 16'h0000, 1'b1, 1'b1);
      tick();
      drive(16'h0200, 16'h0000, 1'b1, 1'b0);
      tick();
      check("b2b_v1", 32'(out_valid), 32'd1);
      check("b2b_c1", 32'(out_c), 32'h0100);
      drive(16'h8400, 16'h0000, 1'b1, 1'b0);
      tick();
      idle_inputs();
      check("b2b_v2", 32'(out_valid), 32'd1);
      check("b2b_c2", 32'(out_c), 32'h0300);
      tick();
      check("b2b_v3", 32'(out_valid), 32'd1);
      check("b2b_c3", 32'(out_c), 32'h8100);
      check("b2b_aovf", 32'(acc_ovf), 32'd0);
      tick();
      single("restart", 16'h0200, 16'h1234, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b0);

      // Backpressure: four accumulates offered while out_ready=0
      bp_a[0] = 16'h0010;
      bp_a[1] = 16'h0020;
      bp_a[2] = 16'h0030;
      bp_a[3] = 16'h0040;
      idx       = 0;
      pops0     = n_pops;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         drive(bp_a[idx], 16'h0000, 1'b1, idx == 0);
         @(negedge clk);
         acc_now = in_ready;
         tick();
         if (acc_now) idx++;
      end
      check("bp_accepts", 32'(idx), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_c", 32'(out_c), 32'h0010);
      out_ready = 1'b1;
      for (int g = 0; g < 20 && idx < 4; g++) begin
         drive(bp_a[idx], 16'h0000, 1'b1, idx == 0);
         @(negedge clk);
         acc_now = in_ready;
         tick();
         if (acc_now) idx++;
      end
      idle_inputs();
      check("bp_all_accepted", 32'(idx), 32'd4);
      drain("bp");
      check("bp_pops", 32'(n_pops - pops0), 32'd4);
      single("bp_acc", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00A0, 1'b0, 1'b0);

      // Accumulator overflow is sticky until the next first=1
      single("aovf_start", 16'h7F00, 16'h0000, 1'b1, 1'b1, 16'h7F00, 1'b0, 1'b0);
      single("aovf_hit", 16'h0200, 16'h0000, 1'b1, 1'b0, EXP_ACC_OVF, 1'b1, 1'b1);
      single("aovf_stick", 16'h8001, 16'h0000, 1'b1, 1'b0, EXP_ACC_AFTER, 1'b0, 1'b1);

      // Reset with both stages full and the output stalled
      out_ready = 1'b0;
      drive(16'h0001, 16'h0001, 1'b0, 1'b0);
      tick();
      tick();
      check("mid_full_in_ready", 32'(in_ready), 32'd0);
      check("mid_full_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_c", 32'(out_c), 32'd0);
      check("mid_rst_acc_ovf", 32'(acc_ovf), 32'd0);
      single("post_rst_acc", 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0);

      // Randomized traffic with random stalls and rare resets
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_acc    = ($urandom_range(0, 1) == 1);
         in_first  = ($urandom_range(0, 7) == 0);
         in_a      = rand_word();
         in_b      = ($urandom_range(0, 3) == 0) ? {~in_a[N-1], in_a[N-2:0]} : rand_word();
         tick();
      end
      rst = 1'b0;
      drain("rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule : tb_qadd_pipe
